// File: rtl/data_memory.sv
// RV32I data memory with load/store alignment unit and a post-reset clear sweep.
// Loads are combinational and extended; stores are byte-enabled on the rising edge.
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [2:0]  funct3,
  output logic [31:0] RD,
  output logic        ready,
  output logic        misaligned,
  output logic        out_of_range
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_idx;
  logic              ready_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              legal_load, legal_store, store_en;
  logic [31:0]       word, rd_raw, wdata;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [3:0]        be;

  assign idx          = A[ADDR_W+1:2];
  assign lane         = A[1:0];
  assign out_of_range = |(A >> (ADDR_W + 2));
  assign ready        = ready_q;

  // Handshake: there is no valid/ready pair on the access side; ready is a level
  // that upstream must observe high before issuing WE, and stores before then are dropped.
  always_comb begin
    legal_load  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    legal_store = funct3 inside {3'b000, 3'b001, 3'b010};
    misaligned  = ((funct3[1:0] == 2'b01) && A[0]) ||
                  ((funct3 == 3'b010) && (lane != 2'b00));
  end

  always_comb begin
    word     = mem[idx];
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = word[{A[1], 4'b0000} +: 16];
    rd_raw   = '0;
    case (funct3)
      3'b000:  rd_raw = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  rd_raw = {{16{half_sel[15]}}, half_sel};
      3'b010:  rd_raw = word;
      3'b100:  rd_raw = {24'b0, byte_sel};
      3'b101:  rd_raw = {16'b0, half_sel};
      default: rd_raw = '0;
    endcase
    RD = (ready_q && !misaligned && !out_of_range && legal_load) ? rd_raw : '0;
  end

  always_comb begin
    be    = 4'b0000;
    wdata = WD;
    case (funct3)
      3'b000: begin
        be    = 4'b0001 << lane;
        wdata = {4{WD[7:0]}};
      end
      3'b001: begin
        be    = A[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WD[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    store_en = WE && ready_q && !misaligned && !out_of_range && legal_store;
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_idx == LAST_IDX) state_next = READY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == READY);
      if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
    end
  end

  // The array itself has no reset; the sweep zeroes it after every rst release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (store_en) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: directed steps and random accesses against a byte-level
// reference model of the memory, the clear sweep and the load/store rules.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst, WE;
  logic [31:0] A, WD, RD;
  logic [2:0]  funct3;
  logic        ready, misaligned, out_of_range;

  int total = 0;
  int bad   = 0;
  int n;

  logic [7:0] mb [1024];
  bit         m_ready = 1'b0;
  int         m_cnt   = 0;

  always #5 clk = ~clk;

  data_memory dut (
    .clk(clk), .rst(rst), .WE(WE), .A(A), .WD(WD), .funct3(funct3),
    .RD(RD), .ready(ready), .misaligned(misaligned), .out_of_range(out_of_range)
  );

  function automatic bit m_mis(input logic [31:0] a, input logic [2:0] f);
    return (((f == 3'd1) || (f == 3'd5)) && a[0]) || ((f == 3'd2) && (a % 4 != 0));
  endfunction

  function automatic bit m_oor(input logic [31:0] a);
    return a >= 32'd1024;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f);
    int          ai, hb, wb;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    if (!m_ready || m_mis(a, f) || m_oor(a) || !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
      return 32'h0;
    ai = int'(a);
    hb = ai - (ai % 2);
    wb = ai - (ai % 4);
    b  = mb[ai];
    h  = {mb[hb+1], mb[hb]};
    w  = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
    case (f)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return w;
      3'd4:    return {24'h0, b};
      default: return {16'h0, h};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rd"},    RD,                   m_load(A, funct3));
    check({tag, "_mis"},   {31'b0, misaligned},  {31'b0, m_mis(A, funct3)});
    check({tag, "_oor"},   {31'b0, out_of_range}, {31'b0, m_oor(A)});
    check({tag, "_ready"}, {31'b0, ready},       {31'b0, m_ready});
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f);
    WE = we; A = a; WD = wd; funct3 = f;
    #1;
  endtask

  // One rising edge; the model applies the same edge using the pre-edge inputs.
  task automatic tick();
    logic        r, w;
    logic [31:0] a, d;
    logic [2:0]  f;
    int          ai;
    r = rst; w = WE; a = A; d = WD; f = funct3;
    @(posedge clk);
    ai = int'(a);
    if (r) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      for (int k = 0; k < 4; k++) mb[m_cnt*4 + k] = 8'h00;
      m_cnt++;
      if (m_cnt == 256) m_ready = 1'b1;
    end else if (w && !m_mis(a, f) && !m_oor(a) && (f inside {3'd0, 3'd1, 3'd2})) begin
      mb[ai] = d[7:0];
      if (f != 3'd0) mb[ai+1] = d[15:8];
      if (f == 3'd2) begin
        mb[ai+2] = d[23:16];
        mb[ai+3] = d[31:24];
      end
    end
    #1;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f,
                    input logic [31:0] exp);
    drive(1'b0, a, 32'h0, f);
    check(tag, RD, exp);
    check({tag, "_model"}, RD, m_load(a, f));
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f);
    drive(1'b1, a, wd, f);
    tick();
    drive(1'b0, a, 32'h0, f);
  endtask

  task automatic wait_ready(input string tag);
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      tick();
      n++;
      check({tag, "_sweep"}, {31'b0, ready}, {31'b0, m_ready});
    end
    check({tag, "_latency"}, n, 32'd256);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 3'd2);
    tick();
    tick();
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_rd", RD, 32'h0);
    rst = 1'b0;
    wait_ready("init");
    ld("lw_0", 32'h0, 3'd2, 32'h0);
    ld("lw_3fc", 32'h3FC, 3'd2, 32'h0);

    st(32'h10, 32'hDEADBEEF, 3'd2);
    ld("lw_10", 32'h10, 3'd2, 32'hDEADBEEF);
    ld("lb_10", 32'h10, 3'd0, 32'hFFFFFFEF);
    ld("lbu_13", 32'h13, 3'd4, 32'h000000DE);
    ld("lh_12", 32'h12, 3'd1, 32'hFFFFDEAD);
    ld("lhu_10", 32'h10, 3'd5, 32'h0000BEEF);

    st(32'h11, 32'h12345655, 3'd0);
    ld("sb_11", 32'h10, 3'd2, 32'hDEAD55EF);
    st(32'h12, 32'h0000A5A5, 3'd1);
    ld("sh_12", 32'h10, 3'd2, 32'hA5A555EF);

    drive(1'b1, 32'h12, 32'h11111111, 3'd2);
    check("sw_mis_flag", {31'b0, misaligned}, 32'h1);
    tick();
    ld("sw_mis_keep", 32'h10, 3'd2, 32'hA5A555EF);

    drive(1'b0, 32'h11, 32'h0, 3'd1);
    check("lh_mis_flag", {31'b0, misaligned}, 32'h1);
    check("lh_mis_rd", RD, 32'h0);

    drive(1'b1, 32'h10, 32'hFFFFFFFF, 3'd3);
    check("ill_rd", RD, 32'h0);
    check("ill_mis", {31'b0, misaligned}, 32'h0);
    tick();
    ld("ill_keep", 32'h10, 3'd2, 32'hA5A555EF);

    drive(1'b0, 32'h400, 32'h0, 3'd2);
    check("oor_flag", {31'b0, out_of_range}, 32'h1);
    check("oor_rd", RD, 32'h0);
    st(32'h400, 32'h77777777, 3'd2);
    ld("oor_keep", 32'h0, 3'd2, 32'h0);

    st(32'h20, 32'h11112222, 3'd2);
    drive(1'b1, 32'h20, 32'h33334444, 3'd2);
    check("rdw_old", RD, 32'h11112222);
    tick();
    ld("rdw_new", 32'h20, 3'd2, 32'h33334444);

    repeat (400) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      drive(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
      check_all("rnd");
      tick();
    end

    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 3'd2);
    tick();
    check("rst_in_ready", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      if (n == 150) drive(1'b1, 32'h14, 32'hCAFEF00D, 3'd2);
      else          drive(1'b0, 32'h14, 32'h0, 3'd2);
      tick();
      n++;
      check("restart_sweep", {31'b0, ready}, {31'b0, m_ready});
    end
    check("restart_latency", n, 32'd256);
    ld("clr_we_ignored", 32'h14, 3'd2, 32'h0);
    ld("reclear_10", 32'h10, 3'd2, 32'h0);
    ld("reclear_20", 32'h20, 3'd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
